// File: rtl/pc_predict.sv
// -----------------------------------------------------------------------------
// pc_predict -- fetch PC generator with an optional direct-mapped BTB predictor.
//
// Optional feature macro: PC_PREDICT_EN
//   defined   : BTB (valid, tag, 30-bit target, 2-bit counter per entry) is
//               built; pred_taken and next-pc follow the BTB lookup.
//   undefined : no BTB storage; pred_taken is 0, next pc is pc+4, and the
//               upd_* inputs are ignored.
//
// Parameters
//   RESET_PC    : PC value loaded while in reset and held until ce rises.
//   BTB_ENTRIES : BTB depth; must be a power of two and at least 2.
//
// Ports
//   clk         : in  clock, all state updates on the rising edge
//   rst         : in  asynchronous active-high reset
//   stall       : in  hold the current pc
//   redirect    : in  execute-stage mispredict, load redirect_pc
//   redirect_pc : in  [31:0] corrected fetch address
//   upd_valid   : in  a branch resolved this cycle (upd_pc/target/taken valid)
//   upd_pc      : in  [31:0] address of the resolved branch
//   upd_target  : in  [31:0] resolved branch target
//   upd_taken   : in  resolved branch direction
//   pc          : out [31:0] fetch address (instruction ROM addr)
//   ce          : out fetch enable (instruction ROM ce)
//   pred_taken  : out prediction for the current pc (ROM input_isTaken)
//
// Handshake: upd_valid is a single-cycle qualifier with no back-pressure;
// every cycle it is high the BTB absorbs one update. redirect likewise acts
// in every cycle it is high. Both are independent and may coincide.
// -----------------------------------------------------------------------------
module pc_predict #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output logic [31:0] pc,
   output logic        ce,
   output logic        pred_taken
);

   logic [31:0] pc_q, pc_d;
   logic        ce_q;
   logic [31:0] pred_target;

`ifdef PC_PREDICT_EN
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             btb_val_q [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag_q [BTB_ENTRIES];
   logic [29:0]      btb_tgt_q [BTB_ENTRIES];
   logic [1:0]       btb_ctr_q [BTB_ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic             unused_upd_low;

   // Lookup reads the registered array, so a same-cycle update to the same
   // index is only visible from the next cycle on.
   assign lk_idx      = pc_q[IDX_W+1:2];
   assign lk_tag      = pc_q[31:IDX_W+2];
   assign lk_hit      = btb_val_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
   assign pred_taken  = ce_q & lk_hit & btb_ctr_q[lk_idx][1];
   assign pred_target = {btb_tgt_q[lk_idx], 2'b00};

   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[31:IDX_W+2];
   assign up_hit = btb_val_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

   // Targets are stored word-aligned; the byte-offset bits are dropped.
   assign unused_upd_low = ^upd_target[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_val_q[i] <= 1'b0;
            btb_tag_q[i] <= '0;
            btb_tgt_q[i] <= '0;
            btb_ctr_q[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            if (upd_taken) begin
               if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'b01;
               btb_tgt_q[up_idx] <= upd_target[31:2];
            end else if (btb_ctr_q[up_idx] != 2'b00) begin
               btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'b01;
            end
         end else if (upd_taken) begin
            // Allocate weakly-taken, evicting whatever aliased here before.
            btb_val_q[up_idx] <= 1'b1;
            btb_tag_q[up_idx] <= up_tag;
            btb_tgt_q[up_idx] <= upd_target[31:2];
            btb_ctr_q[up_idx] <= 2'b10;
         end
      end
   end
`else
   logic unused_upd;

   assign pred_taken  = 1'b0;
   assign pred_target = 32'h0000_0000;
   assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};
`endif

   // Next-pc: until fetch is enabled the pc stays at RESET_PC; afterwards
   // redirect beats stall, and stall beats the prediction.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (!ce_q) begin
         pc_d = RESET_PC;
      end else if (redirect) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
         ce_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         ce_q <= 1'b1;
      end
   end

   assign pc = pc_q;
   assign ce = ce_q;

endmodule

// File: tb/tb_pc_predict.sv
module tb_pc_predict;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int N    = 16;
   localparam int IDXW = 4;
`ifdef PC_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   // clock / reset
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        stall, redirect, upd_valid, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] pc;
   logic        ce, pred_taken;

   pc_predict #(.RESET_PC(RESET_PC), .BTB_ENTRIES(N)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken),
      .pc(pc), .ce(ce), .pred_taken(pred_taken)
   );

   // scoreboard: {ce, pred_taken, pc}
   logic [33:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [33:0] act, logic [33:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got ce=%0b pred=%0b pc=%h, expected ce=%0b pred=%0b pc=%h",
                  name, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
      end
   endtask

   // reference model: BTB kept as owner address / target address / counter
   bit          m_val[N];
   logic [31:0] m_own[N];
   logic [31:0] m_tgt[N];
   int          m_ctr[N];
   bit          m_ce;
   logic [31:0] m_pc;

   function automatic int idx_of(logic [31:0] a);
      return int'((a >> 2) % N);
   endfunction

   function automatic bit m_hit(logic [31:0] a);
      int i = idx_of(a);
      return PRED_EN && m_val[i] && ((m_own[i] >> (IDXW + 2)) == (a >> (IDXW + 2)));
   endfunction

   function automatic bit m_pred();
      return m_ce && m_hit(m_pc) && (m_ctr[idx_of(m_pc)] >= 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_val[i] = 1'b0;
         m_own[i] = '0;
         m_tgt[i] = '0;
         m_ctr[i] = 1;
      end
      m_ce = 1'b0;
      m_pc = RESET_PC;
   endtask

   task automatic model_advance(bit rd, logic [31:0] rpc, bit st,
                                bit uv, logic [31:0] upc, logic [31:0] utg, bit ut);
      bit          p = m_pred();
      logic [31:0] t = m_tgt[idx_of(m_pc)];
      int          i;
      if (!m_ce) begin
         m_ce = 1'b1;
         m_pc = RESET_PC;
      end else if (rd) m_pc = rpc;
      else if (st) m_pc = m_pc;
      else if (p) m_pc = t;
      else m_pc = m_pc + 32'd4;
      if (PRED_EN && uv) begin
         i = idx_of(upc);
         if (m_hit(upc)) begin
            if (ut) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = utg & ~32'd3;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (ut) begin
            m_val[i] = 1'b1;
            m_own[i] = upc;
            m_tgt[i] = utg & ~32'd3;
            m_ctr[i] = 2;
         end
      end
   endtask

   // driver: called at a falling edge, drives one cycle of inputs
   task automatic step(bit rd, logic [31:0] rpc, bit st,
                       bit uv, logic [31:0] upc, logic [31:0] utg, bit ut);
      redirect = rd; redirect_pc = rpc; stall = st;
      upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = ut;
      exp_q.push_back({m_ce, m_pred(), m_pc});
      model_advance(rd, rpc, st, uv, upc, utg, ut);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   // Reset pulse placed between edges with a redirect and an update pending.
   task automatic mid_reset();
      redirect = 1'b1; redirect_pc = 32'h300; stall = 1'b0;
      upd_valid = 1'b1; upd_pc = 32'h300; upd_target = 32'h40; upd_taken = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      check("async_reset", {ce, pred_taken, pc}, {1'b0, 1'b0, RESET_PC});
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset_held", {ce, pred_taken, pc}, {1'b0, 1'b0, RESET_PC});
      rst = 1'b0;
      redirect = 1'b0; upd_valid = 1'b0;
   endtask

   logic [31:0] addrs[6];

   task automatic random_phase(int cycles);
      for (int k = 0; k < cycles; k++) begin
         step($urandom_range(0, 7) == 0, addrs[$urandom_range(0, 5)],
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) == 0, addrs[$urandom_range(0, 5)],
              addrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
      end
   endtask

   // monitor: compares every presented output against the queue head
   initial begin
      logic [33:0] e;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_out", {ce, pred_taken, pc}, e);
         end
      end
   end

   initial begin
      addrs[0] = 32'h40;  addrs[1] = 32'h44;  addrs[2] = 32'h100;
      addrs[3] = 32'h140; addrs[4] = 32'h200; addrs[5] = 32'hFFFF_FFFC;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", {ce, pred_taken, pc}, {1'b0, 1'b0, RESET_PC});
      rst = 1'b0;

      // release: pc 0, 0, 4, 8, 12 with ce 0 then 1
      repeat (5) idle();

      // allocate 0x40 -> 0x100 taken, then fetch through it
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1);
      step(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) idle();

      // two not-taken updates weaken the entry; 0x40 falls through to 0x44
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
      step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (2) idle();

      // redirect beats stall, then stall holds for three cycles
      step(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      idle();

      // wrap at the top of the address space
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (2) idle();

      // update and lookup of the same index in one cycle
      step(1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h140, 32'h44, 1'b1);
      repeat (2) idle();

      random_phase(300);

      // re-train 0x40 strongly, then reset mid-run and confirm it is gone
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1);
      mid_reset();
      repeat (2) idle();
      step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (2) idle();
      step(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (2) idle();

      random_phase(150);

      repeat (2) @(negedge clk);
      #3;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
